// File: rtl/bram_arbiter.sv
`timescale 1ns/1ps
// Purpose: shares one simple-dual-port BRAM between requesters A and B; optional post-reset clear sweep.
// Latency: request accepted at edge k -> BRAM port driven after k -> x_rvalid/x_rdata high after edge k+2.
// Backpressure: combinational x_ready; an ungranted requester holds its request; read responses cannot be stalled.
//
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   a_* / b_*                     valid/ready request (we, addr, wdata) and rvalid/rdata response per requester
//   bram_wr_en/addr/data          registered BRAM write port
//   bram_rd_addr, bram_rd_data    registered BRAM read address, data returned one cycle later
//   init_done                     high once the clear sweep has finished (or immediately without sweep)
module bram_arbiter #(
    parameter int               ABITS          = 8,
    parameter int               DBITS          = 8,
    parameter bit               CLEAR_ON_RESET = 1'b1,
    parameter logic [DBITS-1:0] CLEAR_VALUE    = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic             a_we,
    input  logic [ABITS-1:0] a_addr,
    input  logic [DBITS-1:0] a_wdata,
    output logic             a_rvalid,
    output logic [DBITS-1:0] a_rdata,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic             b_we,
    input  logic [ABITS-1:0] b_addr,
    input  logic [DBITS-1:0] b_wdata,
    output logic             b_rvalid,
    output logic [DBITS-1:0] b_rdata,
    output logic             bram_wr_en,
    output logic [ABITS-1:0] bram_wr_addr,
    output logic [DBITS-1:0] bram_wr_data,
    output logic [ABITS-1:0] bram_rd_addr,
    input  logic [DBITS-1:0] bram_rd_data,
    output logic             init_done
);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    localparam logic [ABITS-1:0] LAST_ADDR = '1;

    state_t           state;
    state_t           state_nxt;
    logic [ABITS-1:0] clr_cnt;
    logic             rr_ptr;       // 0: A wins the next contention, 1: B wins

    logic             run;
    logic             a_rd, a_wr, b_rd, b_wr;
    logic             rd_conflict, wr_conflict;
    logic             rd_gnt_a, rd_gnt_b, wr_gnt_a, wr_gnt_b;
    logic             rd_any, wr_any, collide;
    logic [ABITS-1:0] rd_addr_sel, wr_addr_sel;
    logic [DBITS-1:0] wr_data_sel;

    // Read tag pipeline: stage 1 = address at BRAM, stage 2 = data on bram_rd_data.
    logic             s1_vld, s1_b, s2_vld, s2_b;

    always_comb begin
        state_nxt   = state;
        run         = (state == ST_RUN) && !rst;
        a_rd        = run && a_valid && !a_we;
        a_wr        = run && a_valid &&  a_we;
        b_rd        = run && b_valid && !b_we;
        b_wr        = run && b_valid &&  b_we;
        rd_conflict = a_rd && b_rd;
        wr_conflict = a_wr && b_wr;

        rd_gnt_a    = a_rd && (!b_rd || !rr_ptr);
        rd_gnt_b    = b_rd && (!a_rd ||  rr_ptr);
        rd_any      = rd_gnt_a || rd_gnt_b;
        rd_addr_sel = rd_gnt_b ? b_addr : a_addr;

        wr_gnt_a    = a_wr && (!b_wr || !rr_ptr);
        wr_gnt_b    = b_wr && (!a_wr ||  rr_ptr);
        wr_addr_sel = wr_gnt_b ? b_addr  : a_addr;
        wr_data_sel = wr_gnt_b ? b_wdata : a_wdata;

        // A write to the address being read this cycle waits one cycle so the
        // read returns the old contents without relying on BRAM collision rules.
        collide = rd_any && (wr_gnt_a || wr_gnt_b) && (rd_addr_sel == wr_addr_sel);
        if (collide) begin
            wr_gnt_a = 1'b0;
            wr_gnt_b = 1'b0;
        end
        wr_any  = wr_gnt_a || wr_gnt_b;

        a_ready = rd_gnt_a || wr_gnt_a;
        b_ready = rd_gnt_b || wr_gnt_b;

        if (state == ST_CLEAR && clr_cnt == LAST_ADDR) begin
            state_nxt = ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            clr_cnt      <= '0;
            rr_ptr       <= 1'b0;
            init_done    <= 1'b0;
            bram_wr_en   <= 1'b0;
            bram_wr_addr <= '0;
            bram_wr_data <= '0;
            bram_rd_addr <= '0;
            s1_vld       <= 1'b0;
            s1_b         <= 1'b0;
            s2_vld       <= 1'b0;
            s2_b         <= 1'b0;
            a_rvalid     <= 1'b0;
            b_rvalid     <= 1'b0;
            a_rdata      <= '0;
            b_rdata      <= '0;
        end else begin
            state     <= state_nxt;
            init_done <= (state_nxt == ST_RUN);

            if (state == ST_CLEAR) begin
                clr_cnt      <= clr_cnt + 1'b1;
                bram_wr_en   <= 1'b1;
                bram_wr_addr <= clr_cnt;
                bram_wr_data <= CLEAR_VALUE;
            end else begin
                bram_wr_en <= wr_any;
                if (wr_any) begin
                    bram_wr_addr <= wr_addr_sel;
                    bram_wr_data <= wr_data_sel;
                end
            end

            if (rd_any) begin
                bram_rd_addr <= rd_addr_sel;
            end

            // Only one of the two can be set in a cycle: each requester has one request.
            if (rd_conflict || wr_conflict) begin
                rr_ptr <= ~rr_ptr;
            end

            s1_vld   <= rd_any;
            s1_b     <= rd_gnt_b;
            s2_vld   <= s1_vld;
            s2_b     <= s1_b;
            a_rvalid <= s2_vld && !s2_b;
            b_rvalid <= s2_vld &&  s2_b;
            if (s2_vld && !s2_b) begin
                a_rdata <= bram_rd_data;
            end
            if (s2_vld && s2_b) begin
                b_rdata <= bram_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_bram_arbiter.sv
`timescale 1ns/1ps
// Bench for bram_arbiter: directed scenarios plus mixed random traffic, with a
// per-port scoreboard checking read data and response cycle against expectations.
module tb_bram_arbiter;

    localparam logic [7:0] CLR = 8'hA5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a_valid = 1'b0, a_we = 1'b0;
    logic [7:0] a_addr = '0, a_wdata = '0;
    logic       b_valid = 1'b0, b_we = 1'b0;
    logic [7:0] b_addr = '0, b_wdata = '0;
    logic       a_ready, a_rvalid, b_ready, b_rvalid;
    logic [7:0] a_rdata, b_rdata;
    logic       bram_wr_en, init_done;
    logic [7:0] bram_wr_addr, bram_wr_data, bram_rd_addr, bram_rd_data;

    always #5 clk = ~clk;

    bram_arbiter #(
        .ABITS(8), .DBITS(8), .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(CLR)
    ) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr),
        .a_wdata(a_wdata), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr),
        .b_wdata(b_wdata), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .bram_wr_en(bram_wr_en), .bram_wr_addr(bram_wr_addr), .bram_wr_data(bram_wr_data),
        .bram_rd_addr(bram_rd_addr), .bram_rd_data(bram_rd_data), .init_done(init_done)
    );

    // Simple-dual-port BRAM with one-cycle synchronous read.
    logic [7:0] bram_mem [256];
    always @(posedge clk) begin
        if (bram_wr_en) bram_mem[bram_wr_addr] <= bram_wr_data;
        bram_rd_data <= bram_mem[bram_rd_addr];
    end

    typedef struct {
        logic [7:0] dat;
        int         due;
    } exp_t;

    exp_t       qa[$];
    exp_t       qb[$];
    logic [7:0] ref_mem [256];
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    logic       a_acc = 1'b0, b_acc = 1'b0, done_s = 1'b0;
    logic       use_model = 1'b0, suppress = 1'b0;
    logic [7:0] a_hand = '0, b_hand = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every response pops the oldest expectation for its port.
    exp_t ea, eb;
    always @(negedge clk) begin
        if (a_rvalid === 1'b1) begin
            if (qa.size() == 0) begin
                check("a_unexpected_rvalid", 32'd1, 32'd0);
            end else begin
                ea = qa.pop_front();
                check("a_rdata", {24'd0, a_rdata}, {24'd0, ea.dat});
                check("a_resp_cycle", cyc, ea.due);
            end
        end
        if (b_rvalid === 1'b1) begin
            if (qb.size() == 0) begin
                check("b_unexpected_rvalid", 32'd1, 32'd0);
            end else begin
                eb = qb.pop_front();
                check("b_rdata", {24'd0, b_rdata}, {24'd0, eb.dat});
                check("b_resp_cycle", cyc, eb.due);
            end
        end
    end

    task automatic init_ref();
        for (int i = 0; i < 256; i++) ref_mem[i] = CLR;
    endtask

    // One clock: sample handshakes before the edge, record expectations, then
    // return just after the edge with accepted requests dropped.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        a_acc  = a_valid && a_ready;
        b_acc  = b_valid && b_ready;
        done_s = init_done;
        if (a_acc && !a_we && !suppress) begin
            e.dat = use_model ? ref_mem[a_addr] : a_hand;
            e.due = cyc + 3;
            qa.push_back(e);
        end
        if (b_acc && !b_we && !suppress) begin
            e.dat = use_model ? ref_mem[b_addr] : b_hand;
            e.due = cyc + 3;
            qb.push_back(e);
        end
        if (a_acc && a_we) ref_mem[a_addr] = a_wdata;
        if (b_acc && b_we) ref_mem[b_addr] = b_wdata;
        @(posedge clk);
        #1;
        if (a_acc) a_valid = 1'b0;
        if (b_acc) b_valid = 1'b0;
    endtask

    task automatic req_a(input logic we, input logic [7:0] addr, input logic [7:0] wd, input logic [7:0] hand);
        a_valid = 1'b1; a_we = we; a_addr = addr; a_wdata = wd; a_hand = hand;
    endtask

    task automatic req_b(input logic we, input logic [7:0] addr, input logic [7:0] wd, input logic [7:0] hand);
        b_valid = 1'b1; b_we = we; b_addr = addr; b_wdata = wd; b_hand = hand;
    endtask

    task automatic run_until_idle(input int limit);
        int n;
        n = 0;
        while ((a_valid || b_valid) && n < limit) begin
            cycle();
            n++;
        end
        check("handshake_timeout", {31'd0, a_valid || b_valid}, 32'd0);
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    // Called just after a reset edge: releases reset with an A read of 0x37 pending
    // and measures how long the clear sweep holds off the grant.
    task automatic clear_phase(input string tag);
        int n, done_early;
        n = 0;
        done_early = 0;
        req_a(1'b0, 8'h37, 8'h00, CLR);
        rst   = 1'b0;
        a_acc = 1'b0;
        while (!a_acc && n < 400) begin
            cycle();
            if (!a_acc) begin
                n++;
                if (done_s) done_early++;
            end
        end
        check({tag, "_clear_len"}, n, 256);
        check({tag, "_init_done_early"}, done_early, 0);
        check({tag, "_init_done_run"}, {31'd0, done_s}, 32'd1);
        a_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        init_ref();
        use_model = 1'b0;

        // Reset state, with both requesters asking.
        req_a(1'b0, 8'h01, 8'h00, 8'h00);
        req_b(1'b0, 8'h02, 8'h00, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_ready", {31'd0, a_ready}, 32'd0);
        check("rst_b_ready", {31'd0, b_ready}, 32'd0);
        check("rst_a_rvalid", {31'd0, a_rvalid}, 32'd0);
        check("rst_b_rvalid", {31'd0, b_rvalid}, 32'd0);
        check("rst_a_rdata", {24'd0, a_rdata}, 32'd0);
        check("rst_b_rdata", {24'd0, b_rdata}, 32'd0);
        check("rst_wr_en", {31'd0, bram_wr_en}, 32'd0);
        check("rst_wr_addr", {24'd0, bram_wr_addr}, 32'd0);
        check("rst_wr_data", {24'd0, bram_wr_data}, 32'd0);
        check("rst_rd_addr", {24'd0, bram_rd_addr}, 32'd0);
        check("rst_init_done", {31'd0, init_done}, 32'd0);
        b_valid = 1'b0;

        // T1: clear sweep, then A reads 0x37 -> 0xA5.
        clear_phase("t1");

        // T2: write 0x5A @0x10, read it back next cycle.
        req_a(1'b1, 8'h10, 8'h5A, 8'h00);
        run_until_idle(10);
        req_a(1'b0, 8'h10, 8'h00, 8'h5A);
        cycle();
        check("t2_read_accept", {31'd0, a_acc}, 32'd1);
        run_until_idle(10);

        // T3: both read continuously; grants alternate starting with A.
        for (int i = 0; i < 6; i++) begin
            if (!a_valid) req_a(1'b0, 8'h10, 8'h00, 8'h5A);
            if (!b_valid) req_b(1'b0, 8'h37, 8'h00, CLR);
            cycle();
            check("t3_grant_a", {31'd0, a_acc}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check("t3_grant_b", {31'd0, b_acc}, (i % 2 == 1) ? 32'd1 : 32'd0);
        end
        run_until_idle(10);

        // T4: read/write collision on 0x20.
        req_a(1'b1, 8'h20, 8'h11, 8'h00);
        run_until_idle(10);
        req_a(1'b0, 8'h20, 8'h00, 8'h11);
        req_b(1'b1, 8'h20, 8'h77, 8'h00);
        cycle();
        check("t4_a_accept", {31'd0, a_acc}, 32'd1);
        check("t4_b_blocked", {31'd0, b_acc}, 32'd0);
        cycle();
        check("t4_b_accept_next", {31'd0, b_acc}, 32'd1);
        req_a(1'b0, 8'h20, 8'h00, 8'h77);
        run_until_idle(10);

        // T5: read 0x20 and write 0x21 in the same cycle.
        req_a(1'b0, 8'h20, 8'h00, 8'h77);
        req_b(1'b1, 8'h21, 8'h33, 8'h00);
        cycle();
        check("t5_a_accept", {31'd0, a_acc}, 32'd1);
        check("t5_b_accept", {31'd0, b_acc}, 32'd1);
        check("t5_wr_en", {31'd0, bram_wr_en}, 32'd1);
        check("t5_wr_addr", {24'd0, bram_wr_addr}, 32'h21);
        check("t5_wr_data", {24'd0, bram_wr_data}, 32'h33);
        check("t5_rd_addr", {24'd0, bram_rd_addr}, 32'h20);
        req_b(1'b0, 8'h21, 8'h00, 8'h33);
        run_until_idle(10);
        repeat (5) cycle();
        check("t5_qa_drained", qa.size(), 0);
        check("t5_qb_drained", qb.size(), 0);

        // T6: reset one cycle after a read is accepted; the response must vanish.
        suppress = 1'b1;
        req_a(1'b0, 8'h10, 8'h00, 8'h00);
        cycle();
        check("t6_accept", {31'd0, a_acc}, 32'd1);
        rst = 1'b1;
        init_ref();
        @(posedge clk);
        #1;
        check("t6_wr_en", {31'd0, bram_wr_en}, 32'd0);
        check("t6_init_done", {31'd0, init_done}, 32'd0);
        check("t6_a_rdata", {24'd0, a_rdata}, 32'd0);
        check("t6_a_rvalid", {31'd0, a_rvalid}, 32'd0);
        suppress = 1'b0;
        clear_phase("t6");

        // Mixed random traffic on a small address window against the reference memory.
        use_model = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if (!a_valid && $urandom_range(0, 3) != 0) begin
                a_valid = 1'b1;
                a_we    = 1'($urandom_range(0, 1));
                a_addr  = 8'($urandom_range(0, 7));
                a_wdata = 8'($urandom);
            end
            if (!b_valid && $urandom_range(0, 3) != 0) begin
                b_valid = 1'b1;
                b_we    = 1'($urandom_range(0, 1));
                b_addr  = 8'($urandom_range(0, 7));
                b_wdata = 8'($urandom);
            end
            cycle();
        end
        run_until_idle(10);
        repeat (6) cycle();
        check("end_qa_drained", qa.size(), 0);
        check("end_qb_drained", qb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
